// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default widths for the TX and RX paths.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DIV_WIDTH_DEF  = 16;
    localparam int MIN_DIV        = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: load divisor-1 at period entry, terminal count when it reaches zero.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_w,
    input  logic             i_load_w,
    input  logic [WIDTH-1:0] i_load_val_w,
    output logic             o_tc_w
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset_w) begin
        if (i_reset_w) begin
            count <= '0;
        end else if (i_load_w) begin
            count <= i_load_val_w;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign o_tc_w = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 style framing, pulling bytes from an upstream FIFO with a one-cycle read strobe.
//   state | meaning
//   IDLE  | line high, waiting for enable and a non-empty FIFO
//   READ  | read strobe to the FIFO
//   LATCH | capture FIFO data and clamped divisor
//   START | start bit (low)
//   DATA  | data bits, LSB first
//   STOP  | stop bit (high)
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_w,
    input  logic                  i_enable_w,
    input  logic [DIV_WIDTH-1:0]  i_clks_per_bit_w,
    input  logic [DATA_WIDTH-1:0] i_data_w,
    input  logic                  i_empty_w,
    output logic                  o_read_w,
    output logic                  o_tx_w,
    output logic                  o_busy_w
);

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DIV_WIDTH-1:0]  div_reg;
    logic [DIV_WIDTH-1:0]  div_in;
    logic [DIV_WIDTH-1:0]  div_sel;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  baud_load;
    logic                  baud_tc;

    // The START period is loaded on the same edge that latches the divisor,
    // so LATCH feeds the freshly clamped input straight to the counter.
    always_comb begin
        div_in    = (i_clks_per_bit_w < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : i_clks_per_bit_w;
        div_sel   = (state == ST_LATCH) ? div_in : div_reg;
        baud_load = (state == ST_LATCH) ||
                    (baud_tc && ((state == ST_START) || (state == ST_DATA) || (state == ST_STOP)));
    end

    uart_baud_counter #(
        .WIDTH(DIV_WIDTH)
    ) u_baud (
        .i_clk        (i_clk),
        .i_reset_w    (i_reset_w),
        .i_load_w     (baud_load),
        .i_load_val_w (div_sel - DIV_WIDTH'(1)),
        .o_tc_w       (baud_tc)
    );

    always_ff @(posedge i_clk or posedge i_reset_w) begin
        if (i_reset_w) begin
            state     <= ST_IDLE;
            o_tx_w    <= 1'b1;
            o_read_w  <= 1'b0;
            o_busy_w  <= 1'b0;
            shift_reg <= '0;
            div_reg   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_enable_w && !i_empty_w) begin
                        state    <= ST_READ;
                        o_read_w <= 1'b1;
                        o_busy_w <= 1'b1;
                    end
                end
                ST_READ: begin
                    state    <= ST_LATCH;
                    o_read_w <= 1'b0;
                end
                ST_LATCH: begin
                    shift_reg <= i_data_w;
                    div_reg   <= div_in;
                    bit_cnt   <= '0;
                    state     <= ST_START;
                    o_tx_w    <= 1'b0;
                end
                ST_START: begin
                    if (baud_tc) begin
                        state  <= ST_DATA;
                        o_tx_w <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tc) begin
                        if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            state  <= ST_STOP;
                            o_tx_w <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift_reg <= shift_reg >> 1;
                            o_tx_w    <= shift_reg[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_tc) begin
                        state    <= ST_IDLE;
                        o_busy_w <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_tx_w   <= 1'b1;
                    o_read_w <= 1'b0;
                    o_busy_w <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level expected-waveform model checked every cycle, plus literal frame checks.
module tb_uart_tx;

    localparam int DW   = 8;
    localparam int LOGN = 16384;

    logic        i_clk;
    logic        i_reset_w;
    logic        i_enable_w;
    logic [15:0] i_clks_per_bit_w;
    logic [7:0]  i_data_w;
    logic        i_empty_w;
    logic        o_read_w;
    logic        o_tx_w;
    logic        o_busy_w;

    uart_tx dut (
        .i_clk            (i_clk),
        .i_reset_w        (i_reset_w),
        .i_enable_w       (i_enable_w),
        .i_clks_per_bit_w (i_clks_per_bit_w),
        .i_data_w         (i_data_w),
        .i_empty_w        (i_empty_w),
        .o_read_w         (o_read_w),
        .o_tx_w           (o_tx_w),
        .o_busy_w         (o_busy_w)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       tx;
        logic       rd;
        logic       busy;
        logic       expand;
        logic [7:0] data;
    } exp_t;

    exp_t       mq[$];
    logic [7:0] fifo_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         ncyc = 0;
    logic       rd_seen = 1'b0;
    logic       log_tx   [LOGN];
    logic       log_rd   [LOGN];
    logic       log_busy [LOGN];

    function automatic exp_t mk(logic tx, logic rd, logic busy, logic ex, logic [7:0] d);
        exp_t e;
        e.tx = tx; e.rd = rd; e.busy = busy; e.expand = ex; e.data = d;
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    // Every cycle: the expected line state is either idle, or the next entry of a
    // pre-expanded frame waveform (READ, LATCH, then 10 bit periods of the latched divisor).
    always @(negedge i_clk) begin
        exp_t e;
        int   d;
        logic v;
        if (ncyc < LOGN) begin
            log_tx[ncyc]   = o_tx_w;
            log_rd[ncyc]   = o_read_w;
            log_busy[ncyc] = o_busy_w;
        end
        rd_seen = o_read_w;
        if (i_reset_w) begin
            mq.delete();
            e = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
        end else begin
            e = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (i_enable_w && !i_empty_w && fifo_q.size() > 0) begin
                mq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
                mq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, fifo_q[0]));
            end
        end
        chk("tx", int'(o_tx_w), int'(e.tx));
        chk("read", int'(o_read_w), int'(e.rd));
        chk("busy", int'(o_busy_w), int'(e.busy));
        if (!i_reset_w && e.expand) begin
            d = (i_clks_per_bit_w < 16'd2) ? 2 : int'(i_clks_per_bit_w);
            for (int b = 0; b < DW + 2; b++) begin
                v = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : e.data[b-1];
                for (int c = 0; c < d; c++) mq.push_back(mk(v, 1'b0, 1'b1, 1'b0, 8'h00));
            end
        end
        ncyc++;
    end

    // Advance to just after the next rising edge; the FIFO model presents data the cycle after a strobe.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) i_data_w = fifo_q.pop_front();
        i_empty_w = (fifo_q.size() == 0);
    endtask

    task automatic push_byte(logic [7:0] b);
        fifo_q.push_back(b);
        i_empty_w = 1'b0;
    endtask

    function automatic int cnt_rd(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (log_rd[i]) n++;
        return n;
    endfunction

    function automatic int cnt_tx_low(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (!log_tx[i]) n++;
        return n;
    endfunction

    initial begin
        int         t0;
        logic [9:0] pat;
        i_reset_w        = 1'b1;
        i_enable_w       = 1'b0;
        i_clks_per_bit_w = 16'd4;
        i_data_w         = 8'h00;
        i_empty_w        = 1'b1;
        repeat (3) tick();
        chk("rst_tx", int'(o_tx_w), 1);
        chk("rst_read", int'(o_read_w), 0);
        chk("rst_busy", int'(o_busy_w), 0);
        i_reset_w = 1'b0;
        repeat (2) tick();

        // 0xA5 at divisor 4
        i_enable_w = 1'b1;
        i_clks_per_bit_w = 16'd4;
        t0 = ncyc;
        push_byte(8'hA5);
        repeat (50) tick();
        pat = 10'b1_1010_0101_0;
        for (int i = t0; i < t0 + 50; i++) begin
            if (!log_tx[i]) begin
                chk("a5_start_latency", i - t0, 3);
                break;
            end
        end
        for (int j = 0; j < 40; j++) chk("a5_bits", int'(log_tx[t0 + 3 + j]), int'(pat[j/4]));
        chk("a5_latch_high", int'(log_tx[t0 + 2]), 1);
        chk("a5_read_pos", int'(log_rd[t0 + 1]), 1);
        chk("a5_read_count", cnt_rd(t0, t0 + 49), 1);

        // back-to-back 0x01, 0xFF at divisor 2
        i_clks_per_bit_w = 16'd2;
        t0 = ncyc;
        push_byte(8'h01);
        push_byte(8'hFF);
        repeat (60) tick();
        for (int j = 22; j <= 25; j++) chk("b2b_gap_high", int'(log_tx[t0 + j]), 1);
        chk("b2b_second_start", int'(log_tx[t0 + 26]), 0);
        chk("b2b_idle_busy", int'(log_busy[t0 + 23]), 0);
        chk("b2b_stop_busy", int'(log_busy[t0 + 22]), 1);
        chk("b2b_read_busy", int'(log_busy[t0 + 24]), 1);
        chk("b2b_read_count", cnt_rd(t0, t0 + 59), 2);

        // divisor 0 and 1 clamp to 2
        for (int dv = 0; dv < 2; dv++) begin
            i_clks_per_bit_w = 16'(dv);
            t0 = ncyc;
            push_byte(8'h00);
            repeat (30) tick();
            chk("clamp_latch", int'(log_tx[t0 + 2]), 1);
            chk("clamp_low_run", cnt_tx_low(t0, t0 + 29), 18);
            chk("clamp_last_low", int'(log_tx[t0 + 20]), 0);
            chk("clamp_stop", int'(log_tx[t0 + 21]), 1);
        end

        // reset during DATA bit 3 of 0x00
        i_clks_per_bit_w = 16'd4;
        t0 = ncyc;
        push_byte(8'h00);
        repeat (20) tick();
        chk("rst_mid_pre_tx", int'(o_tx_w), 0);
        #2 i_reset_w = 1'b1;
        #1;
        chk("rst_async_tx", int'(o_tx_w), 1);
        chk("rst_async_busy", int'(o_busy_w), 0);
        chk("rst_async_read", int'(o_read_w), 0);
        tick();
        i_reset_w = 1'b0;
        repeat (30) tick();
        chk("rst_no_reread", cnt_rd(t0, ncyc - 1), 1);

        // empty FIFO, then disabled with data waiting
        t0 = ncyc;
        repeat (100) tick();
        chk("empty_reads", cnt_rd(t0, ncyc - 1), 0);
        chk("empty_tx_low", cnt_tx_low(t0, ncyc - 1), 0);
        i_enable_w = 1'b0;
        i_clks_per_bit_w = 16'd3;
        t0 = ncyc;
        push_byte(8'h3C);
        push_byte(8'h81);
        repeat (40) tick();
        chk("disabled_reads", cnt_rd(t0, ncyc - 1), 0);
        chk("disabled_tx_low", cnt_tx_low(t0, ncyc - 1), 0);
        i_enable_w = 1'b1;
        repeat (80) tick();

        // divisor change 5 -> 9 during DATA
        i_clks_per_bit_w = 16'd5;
        t0 = ncyc;
        push_byte(8'h5A);
        push_byte(8'hC3);
        repeat (15) tick();
        i_clks_per_bit_w = 16'd9;
        repeat (140) tick();
        chk("div_f1_bit0", int'(log_tx[t0 + 8]), 0);
        chk("div_f1_bit1", int'(log_tx[t0 + 13]), 1);
        chk("div_f1_bit7", int'(log_tx[t0 + 47]), 0);
        chk("div_f1_stop", int'(log_tx[t0 + 48]), 1);
        chk("div_f2_start_first", int'(log_tx[t0 + 56]), 0);
        chk("div_f2_start_last", int'(log_tx[t0 + 64]), 0);
        chk("div_f2_bit0", int'(log_tx[t0 + 65]), 1);

        // randomized traffic against the frame model
        for (int it = 0; it < 30; it++) begin
            i_clks_per_bit_w = 16'($urandom_range(0, 6));
            i_enable_w = ($urandom_range(0, 9) != 0);
            for (int k = $urandom_range(0, 3); k > 0; k--) push_byte(8'($urandom_range(0, 255)));
            for (int c = $urandom_range(5, 80); c > 0; c--) begin
                tick();
                if ($urandom_range(0, 19) == 0) i_clks_per_bit_w = 16'($urandom_range(0, 6));
                if ($urandom_range(0, 29) == 0) i_enable_w = ~i_enable_w;
            end
        end
        i_enable_w = 1'b1;
        for (int c = 0; c < 3000 && fifo_q.size() > 0; c++) tick();
        repeat (200) tick();
        chk("drain_fifo_empty", fifo_q.size(), 0);
        chk("drain_model_idle", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame and width of the FIFO data bus.
REQ-002 Parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-003 i_clk  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 i_reset_w  input  1  reset; asynchronous, active-high.
REQ-005 i_enable_w  input  1  transmitter enable; level.
REQ-006 i_clks_per_bit_w  input  DIV_WIDTH  i_clk cycles per serial bit.
REQ-007 i_data_w  input  DATA_WIDTH  data from the upstream TX FIFO output port; valid the cycle after a read strobe.
REQ-008 i_empty_w  input  1  upstream TX FIFO empty flag.
REQ-009 o_read_w  output  1  one-cycle read strobe to the TX FIFO.
REQ-010 o_tx_w  output  1  serial line, 8N1 framing, idle high.
REQ-011 o_busy_w  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, READ, LATCH, START, DATA, STOP.
REQ-013 IDLE -> READ when i_enable_w=1 and i_empty_w=0; otherwise stay in IDLE.
REQ-014 o_read_w SHALL be registered and high for exactly the one cycle spent in READ; it is never asserted in any other state.
REQ-015 READ -> LATCH unconditionally; in LATCH the shift register SHALL capture i_data_w and the divisor register SHALL capture max(i_clks_per_bit_w, 2).
REQ-016 LATCH -> START unconditionally; the start bit therefore begins 3 cycles after the IDLE cycle that sees a non-empty FIFO.
REQ-017 o_tx_w SHALL be 0 in START, shift-register bit 0 in DATA, and 1 in IDLE, READ, LATCH, STOP.
REQ-018 Each START, DATA-bit and STOP period SHALL last exactly the latched divisor value in cycles; the baud counter loads divisor-1 at period entry and counts down to 0.
REQ-019 DATA SHALL send DATA_WIDTH bits LSB first, shifting right once per expired bit period; a bit counter (width clog2(DATA_WIDTH)+1) selects DATA -> STOP after the last bit.
REQ-020 STOP -> IDLE when its period expires; back-to-back frames therefore carry 3 idle-high cycles (IDLE, READ, LATCH) between the stop bit and the next start bit.
REQ-021 Changes to i_clks_per_bit_w mid-frame SHALL NOT affect the frame in progress.
REQ-022 Deasserting i_enable_w mid-frame SHALL let the current frame finish; no further read strobes are issued.
REQ-023 i_empty_w SHALL be sampled only in IDLE; the FIFO going empty mid-frame has no effect.
REQ-024 No read strobe SHALL ever be issued while i_empty_w=1 in the issuing cycle.

Reset
REQ-025 While i_reset_w=1, regardless of clock: state IDLE, o_tx_w=1, o_read_w=0, o_busy_w=0, counters and shift register cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with o_tx_w high asynchronously; the aborted byte is not re-read.
REQ-027 After reset deasserts, the first transition out of IDLE SHALL occur no earlier than the first following rising edge.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, DATA_WIDTH default, DIV_WIDTH default and minimum divisor constant (2); it is shared with the RX path.
REQ-029 Sub-module uart_baud_counter (load, terminal-count output, asynchronous reset) SHALL implement REQ-018 and is reused by the future receiver.
REQ-030 The serial output SHALL be driven from a flop, not from combinational decode.

Verification
REQ-031 Divisor 4, FIFO holding 0xA5, enable=1 -> one read pulse; o_tx_w = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; start bit 3 cycles after empty falls.
REQ-032 FIFO holding 0x01, 0xFF, divisor 2 -> two frames, exactly 3 idle-high cycles between them, exactly 2 read pulses, o_busy_w low only in IDLE cycles.
REQ-033 Divisor 0 and divisor 1 -> every bit lasts 2 cycles.
REQ-034 Reset pulsed during DATA bit 3 of 0x00 -> o_tx_w high within the reset cycle with no clock edge; o_busy_w=0; FIFO not re-read.
REQ-035 i_empty_w=1 for 100 cycles, or i_enable_w=0 with FIFO non-empty -> o_read_w never asserted; o_tx_w constant 1.
REQ-036 Divisor changed 5 -> 9 during DATA -> current frame keeps 5-cycle bits; next frame uses 9-cycle bits.
